// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment lit-map table and decode function
//
// Purpose: one table of lit-maps {A,B,C,D,E,F,G} (1 = lit) for hex digits,
// used by both the receive-side decoder and the transmit-side encoder.
// Ports: none (package).
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // Returns {hit, value}; hit=0 means the pattern is not a hex digit.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      SEG_0:   r = {1'b1, 4'h0};
      SEG_1:   r = {1'b1, 4'h1};
      SEG_2:   r = {1'b1, 4'h2};
      SEG_3:   r = {1'b1, 4'h3};
      SEG_4:   r = {1'b1, 4'h4};
      SEG_5:   r = {1'b1, 4'h5};
      SEG_6:   r = {1'b1, 4'h6};
      SEG_7:   r = {1'b1, 4'h7};
      SEG_8:   r = {1'b1, 4'h8};
      SEG_9:   r = {1'b1, 4'h9};
      SEG_A:   r = {1'b1, 4'hA};
      SEG_B:   r = {1'b1, 4'hB};
      SEG_C:   r = {1'b1, 4'hC};
      SEG_D:   r = {1'b1, 4'hD};
      SEG_E:   r = {1'b1, 4'hE};
      SEG_F:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_rx_decoder_if.sv
// rtl/seven_segment_rx_decoder_if.sv - segment input lines and decoded result bus
//
// Purpose: groups the seven segment lines and the decoder results.
// Ports (signals):
//   i_Segment_A..G  : segment lines, driven by master, asynchronous
//   o_Binary_Num    : last decoded value
//   o_Valid         : one-cycle strobe per accepted change
//   o_Error         : accepted pattern not a hex digit
//   o_Blank         : accepted pattern all segments off
//   o_Change_Count  : wrapping count of accepted changes
interface seven_segment_rx_decoder_if #(
  parameter int COUNT_W = 8
);
  logic               i_Segment_A;
  logic               i_Segment_B;
  logic               i_Segment_C;
  logic               i_Segment_D;
  logic               i_Segment_E;
  logic               i_Segment_F;
  logic               i_Segment_G;
  logic [3:0]         o_Binary_Num;
  logic               o_Valid;
  logic               o_Error;
  logic               o_Blank;
  logic [COUNT_W-1:0] o_Change_Count;

  modport master (
    output i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
           i_Segment_E, i_Segment_F, i_Segment_G,
    input  o_Binary_Num, o_Valid, o_Error, o_Blank, o_Change_Count
  );

  modport slave (
    input  i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
           i_Segment_E, i_Segment_F, i_Segment_G,
    output o_Binary_Num, o_Valid, o_Error, o_Blank, o_Change_Count
  );
endinterface

// File: rtl/seven_seg_sync_filter.sv
// rtl/seven_seg_sync_filter.sv - segment synchronizer, normalizer and stability filter
//
// Purpose: brings the pins into i_Clk, converts them to a lit-map and offers
// a pattern for acceptance once it has been stable for STABLE_CLKS cycles.
// Ports:
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Pins[6:0]    : raw pins {A,B,C,D,E,F,G}
//   o_Pattern[6:0] : candidate lit-map, meaningful while o_Accept is high
//   o_Accept       : candidate is stable and differs from the last accepted one
module seven_seg_sync_filter
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CLKS   = 250000,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Pins,
  output logic [6:0] o_Pattern,
  output logic       o_Accept
);

  localparam int              CNT_W   = $clog2(STABLE_CLKS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CLKS - 1);
  // Pin level that means "segment off", so reset looks like a blank display.
  localparam logic [6:0]      PIN_OFF = ACTIVE_LOW_IN ? 7'h7F : 7'h00;

  logic [6:0]       sync_1;
  logic [6:0]       sync_2;
  logic [6:0]       seg;
  logic [6:0]       candidate;
  logic [6:0]       accepted;
  logic [CNT_W-1:0] count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1 <= PIN_OFF;
      sync_2 <= PIN_OFF;
    end else begin
      sync_1 <= i_Pins;
      sync_2 <= sync_1;
    end
  end

  assign seg = ACTIVE_LOW_IN ? ~sync_2 : sync_2;

  // Count saturates at CNT_MAX, so once accepted==candidate no repeat strobe.
  assign o_Accept  = (count == CNT_MAX) && (candidate != accepted);
  assign o_Pattern = candidate;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      candidate <= SEG_BLANK;
      accepted  <= SEG_BLANK;
      count     <= '0;
    end else begin
      if (seg != candidate) begin
        candidate <= seg;
        count     <= '0;
      end else if (count < CNT_MAX) begin
        count <= count + 1'b1;
      end
      if (o_Accept) begin
        accepted <= candidate;
      end
    end
  end

endmodule

// File: rtl/seven_segment_rx_decoder.sv
// rtl/seven_segment_rx_decoder.sv - seven-segment receive decoder top
//
// Purpose: filters the segment lines, decodes accepted patterns to hex and
// reports each accepted change with a strobe and a wrapping counter.
// Ports:
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   bus (slave)    : segment lines in; Binary_Num/Valid/Error/Blank/Change_Count out
module seven_segment_rx_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CLKS   = 250000,
  parameter bit ACTIVE_LOW_IN = 1'b1,
  parameter int COUNT_W       = 8
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  seven_segment_rx_decoder_if.slave   bus
);

  logic [6:0]         pattern;
  logic               accept;
  logic [4:0]         dec;
  logic [3:0]         binary_num;
  logic               valid;
  logic               error;
  logic               blank;
  logic [COUNT_W-1:0] change_count;

  seven_seg_sync_filter #(
    .STABLE_CLKS   (STABLE_CLKS),
    .ACTIVE_LOW_IN (ACTIVE_LOW_IN)
  ) u_filter (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Pins    ({bus.i_Segment_A, bus.i_Segment_B, bus.i_Segment_C,
                 bus.i_Segment_D, bus.i_Segment_E, bus.i_Segment_F,
                 bus.i_Segment_G}),
    .o_Pattern (pattern),
    .o_Accept  (accept)
  );

  assign dec = seg_decode(pattern);

  // Blank and error patterns keep the last good digit on o_Binary_Num.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      binary_num   <= 4'h0;
      valid        <= 1'b0;
      error        <= 1'b0;
      blank        <= 1'b1;
      change_count <= '0;
    end else begin
      valid <= accept;
      if (accept) begin
        change_count <= change_count + 1'b1;
        if (dec[4]) begin
          binary_num <= dec[3:0];
          error      <= 1'b0;
          blank      <= 1'b0;
        end else if (pattern == SEG_BLANK) begin
          error <= 1'b0;
          blank <= 1'b1;
        end else begin
          error <= 1'b1;
          blank <= 1'b0;
        end
      end
    end
  end

  assign bus.o_Binary_Num   = binary_num;
  assign bus.o_Valid        = valid;
  assign bus.o_Error        = error;
  assign bus.o_Blank        = blank;
  assign bus.o_Change_Count = change_count;

endmodule

// File: tb/tb_seven_segment_rx_decoder.sv
// tb/tb_seven_segment_rx_decoder.sv - self-checking bench for seven_segment_rx_decoder
module tb_seven_segment_rx_decoder;

  localparam int STABLE = 4;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seven_segment_rx_decoder_if #(.COUNT_W(8)) bus ();

  seven_segment_rx_decoder #(
    .STABLE_CLKS   (STABLE),
    .ACTIVE_LOW_IN (1'b1),
    .COUNT_W       (8)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  // Digit lit-maps {A..G}, index = hex value.
  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic [6:0] drv_lit = 7'b0;

  // Reference model: a pattern is accepted on the edge after the filter has
  // seen it on STABLE consecutive edges (inputs reach the filter two edges late)
  // and it differs from the last accepted one.
  logic [6:0] m_d1 = 7'b0, m_d2 = 7'b0, m_run_pat = 7'b0, m_acc = 7'b0;
  int         m_run_len = 0;
  logic       exp_valid = 1'b0, exp_err = 1'b0, exp_blank = 1'b1;
  logic [3:0] exp_num = 4'h0;
  logic [7:0] exp_cnt = 8'h0;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic model_step();
    int idx;
    if (!i_Rst_L) begin
      m_d1 = 7'b0; m_d2 = 7'b0; m_run_pat = 7'b0; m_run_len = 0; m_acc = 7'b0;
      exp_valid = 1'b0; exp_num = 4'h0; exp_err = 1'b0; exp_blank = 1'b1; exp_cnt = 8'h0;
    end else begin
      exp_valid = 1'b0;
      if (m_run_len >= STABLE && m_run_pat != m_acc) begin
        m_acc     = m_run_pat;
        exp_valid = 1'b1;
        exp_cnt   = exp_cnt + 8'd1;
        idx       = lookup(m_acc);
        if (idx >= 0) begin
          exp_num = 4'(idx); exp_err = 1'b0; exp_blank = 1'b0;
        end else if (m_acc == 7'b0) begin
          exp_err = 1'b0; exp_blank = 1'b1;
        end else begin
          exp_err = 1'b1; exp_blank = 1'b0;
        end
      end
      if (m_d2 == m_run_pat) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_pat = m_d2;
        m_run_len = 1;
      end
      m_d2 = m_d1;
      m_d1 = drv_lit;
    end
  endtask

  initial forever begin
    @(posedge i_Clk or negedge i_Rst_L);
    model_step();
  end

  task automatic drive(input logic [6:0] lit);
    drv_lit = lit;
    {bus.i_Segment_A, bus.i_Segment_B, bus.i_Segment_C, bus.i_Segment_D,
     bus.i_Segment_E, bus.i_Segment_F, bus.i_Segment_G} = ~lit;
  endtask

  task automatic test_reset();
    int pulses = 0;
    i_Rst_L = 1'b0;
    drive(7'b0);
    repeat (3) @(negedge i_Clk);
    checks++;
    if ({bus.o_Binary_Num, bus.o_Valid, bus.o_Error, bus.o_Blank, bus.o_Change_Count} !== {4'h0, 1'b0, 1'b0, 1'b1, 8'h0}) begin
      failures++;
      $display("FAIL reset_values got num=%0h v=%0b e=%0b b=%0b cnt=%0d exp 0/0/0/1/0",
               bus.o_Binary_Num, bus.o_Valid, bus.o_Error, bus.o_Blank, bus.o_Change_Count);
    end
    i_Rst_L = 1'b1;
    repeat (10) begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.o_Blank !== 1'b1 || bus.o_Change_Count !== 8'h0) begin
      failures++;
      $display("FAIL blank_idle got pulses=%0d blank=%0b cnt=%0d exp 0/1/0", pulses, bus.o_Blank, bus.o_Change_Count);
    end
  endtask

  task automatic test_digit3();
    int first = -1, pulses = 0;
    drive(tbl[3]);
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_Clk);
      checks++;
      if (bus.o_Valid !== exp_valid) begin
        failures++;
        $display("FAIL d3_valid_model k=%0d got=%0b exp=%0b", k, bus.o_Valid, exp_valid);
      end
      if (bus.o_Valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != 7 || pulses != 1) begin
      failures++;
      $display("FAIL d3_latency got first=%0d pulses=%0d exp 7/1", first, pulses);
    end
    checks++;
    if ({bus.o_Binary_Num, bus.o_Error, bus.o_Blank, bus.o_Change_Count} !== {4'h3, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL d3_outputs got num=%0h e=%0b b=%0b cnt=%0d exp 3/0/0/1",
               bus.o_Binary_Num, bus.o_Error, bus.o_Blank, bus.o_Change_Count);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    drive(tbl[8]);
    repeat (2) @(negedge i_Clk);
    drive(tbl[3]);
    repeat (12) begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.o_Binary_Num !== 4'h3 || bus.o_Change_Count !== 8'd1) begin
      failures++;
      $display("FAIL glitch got pulses=%0d num=%0h cnt=%0d exp 0/3/1", pulses, bus.o_Binary_Num, bus.o_Change_Count);
    end
  endtask

  task automatic test_error();
    int pulses = 0;
    drive(7'b1000001);
    repeat (12) begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || {bus.o_Binary_Num, bus.o_Error, bus.o_Blank, bus.o_Change_Count} !== {4'h3, 1'b1, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL invalid_pattern got pulses=%0d num=%0h e=%0b b=%0b cnt=%0d exp 1/3/1/0/2",
               pulses, bus.o_Binary_Num, bus.o_Error, bus.o_Blank, bus.o_Change_Count);
    end
    pulses = 0;
    drive(tbl[15]);
    repeat (12) begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || {bus.o_Binary_Num, bus.o_Error, bus.o_Change_Count} !== {4'hF, 1'b0, 8'd3}) begin
      failures++;
      $display("FAIL recover_F got pulses=%0d num=%0h e=%0b cnt=%0d exp 1/f/0/3",
               pulses, bus.o_Binary_Num, bus.o_Error, bus.o_Change_Count);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1, pulses = 0;
    drive(tbl[5]);
    repeat (5) @(negedge i_Clk);
    i_Rst_L = 1'b0;
    #1;
    checks++;
    if ({bus.o_Binary_Num, bus.o_Valid, bus.o_Error, bus.o_Blank, bus.o_Change_Count} !== {4'h0, 1'b0, 1'b0, 1'b1, 8'h0}) begin
      failures++;
      $display("FAIL async_reset got num=%0h v=%0b e=%0b b=%0b cnt=%0d exp 0/0/0/1/0",
               bus.o_Binary_Num, bus.o_Valid, bus.o_Error, bus.o_Blank, bus.o_Change_Count);
    end
    repeat (2) begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) pulses++;
    end
    i_Rst_L = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != 7 || pulses != 1) begin
      failures++;
      $display("FAIL reset_release_latency got first=%0d pulses=%0d exp 7/1", first, pulses);
    end
    checks++;
    if (bus.o_Binary_Num !== 4'h5 || bus.o_Change_Count !== 8'd1) begin
      failures++;
      $display("FAIL reset_release_digit got num=%0h cnt=%0d exp 5/1", bus.o_Binary_Num, bus.o_Change_Count);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    i_Rst_L = 1'b0;
    drive(7'b0);
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    for (int n = 0; n < 256; n++) begin
      drive(tbl[n % 2]);
      repeat ($urandom_range(7, 9)) begin
        @(negedge i_Clk);
        checks++;
        if (bus.o_Valid !== exp_valid) begin
          failures++;
          $display("FAIL wrap_valid_model n=%0d got=%0b exp=%0b", n, bus.o_Valid, exp_valid);
        end
        if (bus.o_Valid === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 256 || bus.o_Change_Count !== 8'h0 || bus.o_Binary_Num !== 4'h1) begin
      failures++;
      $display("FAIL counter_wrap got pulses=%0d cnt=%0d num=%0h exp 256/0/1", pulses, bus.o_Change_Count, bus.o_Binary_Num);
    end
  endtask

  task automatic test_random();
    logic [6:0] lit;
    int r;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      lit = tbl[$urandom_range(0, 15)];
      else if (r < 7) lit = 7'b0;
      else            lit = 7'($urandom);
      drive(lit);
      repeat ($urandom_range(1, 7)) begin
        @(negedge i_Clk);
        checks++;
        if ({bus.o_Binary_Num, bus.o_Valid, bus.o_Error, bus.o_Blank, bus.o_Change_Count} !==
            {exp_num, exp_valid, exp_err, exp_blank, exp_cnt}) begin
          failures++;
          $display("FAIL random_model n=%0d got num=%0h v=%0b e=%0b b=%0b cnt=%0d exp num=%0h v=%0b e=%0b b=%0b cnt=%0d",
                   n, bus.o_Binary_Num, bus.o_Valid, bus.o_Error, bus.o_Blank, bus.o_Change_Count,
                   exp_num, exp_valid, exp_err, exp_blank, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    drive(7'b0);
    test_reset();
    test_digit3();
    test_glitch();
    test_error();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_rx_decoder.md
Name: seven_segment_rx_decoder

Overview:
Receive side of the seven-segment interface: samples seven externally driven segment lines, which are asynchronous and active-low by default.
- Synchronizes the lines, then requires a pattern to be stable for STABLE_CLKS cycles before accepting it.
- Decodes the accepted pattern back to a 4-bit hex value.
- Reports each accepted change with a one-cycle strobe and keeps a change counter.
- Sits between board-level segment inputs (e.g. a monitored display bus) and downstream logic that consumes digit values.

Parameters:
STABLE_CLKS, 250000, cycles a synchronized pattern must hold before acceptance (10 ms at 25 MHz); minimum 2
ACTIVE_LOW_IN, 1, 1 = segment lit when pin low; 0 = lit when pin high
COUNT_W, 8, width of the change counter

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Segment_A  in  1  segment A line, asynchronous
i_Segment_B  in  1  segment B line, asynchronous
i_Segment_C  in  1  segment C line, asynchronous
i_Segment_D  in  1  segment D line, asynchronous
i_Segment_E  in  1  segment E line, asynchronous
i_Segment_F  in  1  segment F line, asynchronous
i_Segment_G  in  1  segment G line, asynchronous
o_Binary_Num  out  4  last successfully decoded value
o_Valid  out  1  one-cycle strobe on each accepted pattern change
o_Error  out  1  accepted pattern is not in the decode table
o_Blank  out  1  accepted pattern is all segments off
o_Change_Count  out  COUNT_W  number of accepted changes, wraps

Behaviour:
- Reset and clocking:
  - One clock domain, i_Clk.
  - i_Rst_L low asynchronously clears all state.
  - Reset values: o_Binary_Num=0, o_Valid=0, o_Error=0, o_Blank=1, o_Change_Count=0.
  - Internally, the accepted pattern is blank (7'b0 lit-map), the candidate is blank and the stability count is 0.
  - Synchronizer flops reset to the "segment off" pin level (1 when ACTIVE_LOW_IN=1).
- Input path:
  - Each pin passes through a 2-flop synchronizer.
  - The result is normalized to a lit-map seg[6:0] = {A,B,C,D,E,F,G}, where 1 means lit; it is inverted when ACTIVE_LOW_IN=1.
- Stability filter:
  - If seg != candidate: candidate<=seg, count<=0.
  - Else if count < STABLE_CLKS-1: count<=count+1.
  - Count width is clog2(STABLE_CLKS)+1.
- Acceptance:
  - Occurs on the edge where count==STABLE_CLKS-1 and candidate != accepted.
  - The accepted pattern updates and o_Valid is registered high for exactly one cycle.
  - The count stays saturated, so there is no repeat strobe.
- Latency: a pin change held steady produces o_Valid high 2+STABLE_CLKS cycles after the first sampling edge.
- Decode on acceptance. Table is lit-map → value:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Output updates, registered in the same cycle as o_Valid:
  - Table hit: o_Binary_Num<=value, o_Error<=0, o_Blank<=0.
  - Pattern 0000000: o_Blank<=1, o_Error<=0, o_Binary_Num held.
  - Any other pattern: o_Error<=1, o_Blank<=0, o_Binary_Num held.
- o_Change_Count increments on every accepted change (hit, blank or error) and wraps from 2^COUNT_W-1 to 0.
- Boundary conditions:
  - A glitch shorter than STABLE_CLKS, then a return to the accepted pattern: no strobe, outputs unchanged.
  - A glitch to a new pattern shorter than STABLE_CLKS: discarded; the count restarts on return.
  - Patterns alternating faster than STABLE_CLKS: never accepted.
  - Reset asserted mid-filter: the in-progress candidate is lost; no o_Valid during reset or on the first cycle after release.
  - Reset released while pins already show a digit: that digit is accepted after 2+STABLE_CLKS cycles, because the accepted pattern is blank after reset.

Decomposition:
- Shared package seven_seg_pkg:
  - localparams for the 16 lit-map patterns and SEG_BLANK=7'b0000000.
  - A decode function returning {hit, value[3:0]}; shared with the transmit-side encoder so both use one table.
- One sub-module: seven_seg_sync_filter.
  - Contains the synchronizer, normalization and stability counter.
  - Outputs the stable pattern plus an accept pulse.
- The top holds decode, output registers and the counter.

Test Plan:
STABLE_CLKS=4 and ACTIVE_LOW_IN=1 for all scenarios.
1. Reset, then pins all 1 (blank) → o_Blank=1, o_Valid never asserts, o_Change_Count=0.
2. Drive the "3" pattern (pins A,B,C,D,G low) and hold → o_Valid high for one cycle, 6 cycles after the change; o_Binary_Num=3, o_Error=0, o_Blank=0, o_Change_Count=1.
3. From "3", drive "8" for 2 cycles then return to "3" → no o_Valid, o_Binary_Num stays 3, count unchanged.
4. Drive invalid lit-map 1000001 and hold → one o_Valid; o_Error=1, o_Binary_Num stays 3. Then drive "F" → o_Valid, o_Binary_Num=15, o_Error=0.
5. Hold "5", assert i_Rst_L mid-filter (count=2) → outputs return to reset values immediately. After release, "5" is accepted exactly 6 cycles later.
6. Make 256 accepted alternations between "0" and "1" with COUNT_W=8 → o_Change_Count wraps to 0, with exactly 256 o_Valid pulses.
